// File: rtl/multicycle_exec_unit.sv
// multicycle_exec_unit: single-cycle ALU plus iterative shift/mul/div behind a start/busy/done handshake
module multicycle_exec_unit #(
  parameter int WIDTH = 32,
  parameter bit ENABLE_MULDIV = 1'b1,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [SHW-1:0]   shamt,
  input  logic             shamt_sel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             overflow,
  output logic             div_zero,
  output logic             eq,
  output logic             gt,
  output logic             lt
);
  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
  state_t st;
  logic [3:0] op_r;
  logic [WIDTH-1:0] a_r, b_r, p_hi, p_lo;
  logic [SHW:0] cnt;
  logic accept, is_shift, is_md, sgn, div_ge;
  logic [SHW-1:0] n;
  logic [WIDTH-1:0] sum, diff, abs_a, abs_b, ma, mb, alu_res, sh_lo, div_q, div_rem;
  logic [WIDTH-1:0] nh, nl, fin_lo, fin_hi;
  logic [WIDTH:0] mul_sum, div_t;
  logic [2*WIDTH-1:0] mul_p, prod_s;
  logic alu_ovf, fin_ovf, fin_dz;
  assign busy = st == RUN;
  assign done = st == FINISH;
  assign accept = start && st != RUN;
  assign n = shamt_sel ? src_a[SHW-1:0] : shamt;
  assign is_shift = op >= 4'd6 && op <= 4'd8 && n != '0;
  assign is_md = ENABLE_MULDIV && (op == 4'd9 || op == 4'd10);
  assign sum = src_a + src_b;
  assign diff = src_a - src_b;
  assign abs_a = src_a[WIDTH-1] ? -src_a : src_a;
  assign abs_b = src_b[WIDTH-1] ? -src_b : src_b;
  assign ma = a_r[WIDTH-1] ? -a_r : a_r;
  assign mb = b_r[WIDTH-1] ? -b_r : b_r;
  assign sgn = a_r[WIDTH-1] ^ b_r[WIDTH-1];
  assign mul_sum = {1'b0, p_hi} + (p_lo[0] ? {1'b0, ma} : '0);
  assign mul_p = {mul_sum, p_lo[WIDTH-1:1]};
  assign prod_s = sgn ? -mul_p : mul_p;
  assign div_t = {p_hi, p_lo[WIDTH-1]};
  assign div_ge = div_t >= {1'b0, mb};
  assign div_rem = div_ge ? div_t[WIDTH-1:0] - mb : div_t[WIDTH-1:0];
  assign div_q = {p_lo[WIDTH-2:0], div_ge};
  assign sh_lo = op_r == 4'd6 ? p_lo << 1 : {op_r == 4'd8 && p_lo[WIDTH-1], p_lo[WIDTH-1:1]};
  assign nh = op_r == 4'd9 ? mul_sum[WIDTH:1] : op_r == 4'd10 ? div_rem : '0;
  assign nl = op_r == 4'd9 ? mul_p[WIDTH-1:0] : op_r == 4'd10 ? div_q : sh_lo;
  assign fin_dz = op_r == 4'd10 && b_r == '0;
  assign fin_ovf = op_r == 4'd10 && a_r == {1'b1, {(WIDTH-1){1'b0}}} && b_r == '1;
  assign fin_lo = op_r == 4'd9 ? prod_s[WIDTH-1:0] : op_r != 4'd10 ? sh_lo : fin_dz ? '1 : sgn ? -div_q : div_q;
  assign fin_hi = op_r == 4'd9 ? prod_s[2*WIDTH-1:WIDTH] : op_r != 4'd10 ? '0 : fin_dz ? a_r : a_r[WIDTH-1] ? -div_rem : div_rem;
  // single-cycle ALU result and overflow from the live operands
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op)
      4'd0: begin alu_res = sum; alu_ovf = src_a[WIDTH-1] == src_b[WIDTH-1] && sum[WIDTH-1] != src_a[WIDTH-1]; end
      4'd1: begin alu_res = diff; alu_ovf = src_a[WIDTH-1] != src_b[WIDTH-1] && diff[WIDTH-1] != src_a[WIDTH-1]; end
      4'd2: alu_res = src_a & src_b;
      4'd3: alu_res = src_a | src_b;
      4'd4: alu_res = src_a ^ src_b;
      4'd5: alu_res = {{(WIDTH-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      4'd6, 4'd7, 4'd8: alu_res = src_b;
      4'd11: alu_res = src_a;
      default: alu_res = '0;
    endcase
  end
  // control FSM, iteration datapath and registered results
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= IDLE;
      {op_r, a_r, b_r, p_hi, p_lo, cnt} <= '0;
      {result, result_hi, zero, overflow, div_zero, eq, gt, lt} <= '0;
    end else if (accept) begin
      op_r <= op;
      a_r <= src_a;
      b_r <= src_b;
      p_hi <= '0;
      if (is_shift) begin
        st <= RUN;
        cnt <= {1'b0, n};
        p_lo <= src_b;
      end else if (is_md) begin
        st <= RUN;
        cnt <= (SHW+1)'(WIDTH);
        p_lo <= op == 4'd9 ? abs_b : abs_a;
      end else begin
        st <= FINISH;
        result <= alu_res;
        result_hi <= '0;
        zero <= alu_res == '0;
        overflow <= alu_ovf;
        div_zero <= 1'b0;
        eq <= src_a == src_b;
        gt <= $signed(src_a) > $signed(src_b);
        lt <= $signed(src_a) < $signed(src_b);
      end
    end else if (st == RUN) begin
      p_hi <= nh;
      p_lo <= nl;
      cnt <= cnt - 1'b1;
      if (cnt == 1) begin
        st <= FINISH;
        result <= fin_lo;
        result_hi <= fin_hi;
        zero <= fin_lo == '0;
        overflow <= fin_ovf;
        div_zero <= fin_dz;
        eq <= a_r == b_r;
        gt <= $signed(a_r) > $signed(b_r);
        lt <= $signed(a_r) < $signed(b_r);
      end
    end else if (st == FINISH) begin
      st <= IDLE;
    end
  end
endmodule

// File: doc/multicycle_exec_unit.md
Name: multicycle_exec_unit

Overview:
Parametrised successor to the multicycle datapath's logic unit. It is a WIDTH-bit execution unit that provides the single-cycle ALU, iterative shifter, iterative multiply and iterative divide behind a single start/busy/done handshake. The control unit issues an operation with `start` and waits for `done`, instead of relying on fixed cycle counts. Results and flags are registered and held until the next accepted operation.

Parameters:
WIDTH, 32, datapath width in bits; must be a power of two, ≥ 8.
ENABLE_MULDIV, 1, 1 = MULT/DIV implemented; 0 = opcodes 9/10 behave as reserved.
SHW, $clog2(WIDTH), localparam, shift-amount width (not overridable).

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  issue request; sampled only when accepting
op  input  4  operation code (see Behaviour)
src_a  input  WIDTH  operand A
src_b  input  WIDTH  operand B (shift source for shifts)
shamt  input  SHW  immediate shift amount
shamt_sel  input  1  0 = use shamt; 1 = use src_a[SHW-1:0]
busy  output  1  operation in progress
done  output  1  one-cycle pulse; result/flags valid
result  output  WIDTH  main result (LO for MULT/DIV)
result_hi  output  WIDTH  HI for MULT (product high) / DIV (remainder); 0 otherwise
zero  output  1  result == 0
overflow  output  1  signed overflow (ADD/SUB, DIV MIN/-1)
div_zero  output  1  DIV with src_b == 0
eq  output  1  src_a == src_b (operands captured at start)
gt  output  1  signed src_a > src_b
lt  output  1  signed src_a < src_b

Behaviour:
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed, result 0/1), 11 PASSA.
  - 6 SLL, 7 SRL, 8 SRA.
  - 9 MULT (signed), 10 DIV (signed).
  - 12-15 reserved: result 0, single-cycle.
- States: IDLE, RUN, FINISH.
- Accepting condition: state IDLE, or state FINISH (this permits back-to-back issue).
- `start` when not accepting is ignored; no queueing.
- On accept (edge k): latch op, src_a, src_b and the effective shift amount; compute eq/gt/lt from the latched operands.
- Single-cycle ops: go straight to FINISH; `done` = 1 in cycle k+1.
- Shifts: shift one bit per cycle in RUN.
  - Effective amount n: `done` in cycle k+n+1.
  - n = 0: behaves as a single-cycle op, result = src_b.
- MULT: shift-add on operand magnitudes, WIDTH iterations; `done` in cycle k+WIDTH+1.
  - {result_hi, result} = 2·WIDTH-bit signed product.
  - overflow = 0.
- DIV: restoring division on magnitudes, WIDTH iterations; `done` in cycle k+WIDTH+1.
  - Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
  - src_b == 0: div_zero = 1, result = all ones, result_hi = src_a; latency unchanged.
  - src_a == MIN and src_b == −1: result = MIN, result_hi = 0, overflow = 1.
- busy: 1 in every RUN cycle; 0 in IDLE and FINISH.
- done: 1 only in FINISH, then the unit returns to IDLE unless a new start is accepted.
- result, result_hi and flags update only on the edge entering FINISH; they hold until the next FINISH.
- zero is evaluated on result only, not result_hi.
- overflow for ADD/SUB: standard two's-complement overflow. All other ops not listed above: overflow = 0.
- div_zero = 0 for all non-DIV ops.
- reset (synchronous, any state including mid-RUN): state IDLE, all outputs 0, internal counters/accumulators cleared. An in-flight operation is discarded with no `done`.
- start and reset asserted together: reset wins.

Test Plan:
- Reset, then ADD 0x7FFFFFFF + 1 → done one cycle after start, result 0x80000000, overflow 1, zero 0, busy never high.
- SUB 5 − 5 immediately followed by SLT −1, 2 (start held during FINISH) → first done: result 0, zero 1, eq 1; next cycle done: result 1, lt 1.
- SRA 0x80000000 by shamt 4 (shamt_sel 0) → busy 4 cycles, done at k+5, result 0xF8000000. SLL with src_a[4:0] = 0 (shamt_sel 1) → done at k+1, result = src_b.
- MULT −3 × 7 → done at k+33 (WIDTH = 32), result 0xFFFFFFEB, result_hi 0xFFFFFFFF. A start pulse mid-operation is ignored.
- DIV −7 / 2 → result 0xFFFFFFFD, result_hi 0xFFFFFFFF. DIV 9 / 0 → div_zero 1, result 0xFFFFFFFF, result_hi 9. DIV 0x80000000 / −1 → overflow 1.
- Reset asserted in the 10th cycle of a DIV → next cycle busy 0, done 0, outputs 0, and no done ever appears. WIDTH = 8 regression: MULT 0x80 × 0x80 → {hi, lo} = 0x4000, done at k+9.
